// File: rtl/dmem_stall_ctrl.sv
// Memory-stage load/store sequencer: drives the req/ack data bus,
// stalls the EX/MEM register while busy, aligns store data, extends loads.
module dmem_stall_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mem_req_m,
  input  logic          mem_write_m,
  input  logic [2:0]    func3_m,
  input  logic [DW-1:0] addr_m,
  input  logic [DW-1:0] wdata_m,
  output logic          stall_o,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [DW-1:0] dbus_addr_o,
  output logic [3:0]    dbus_be_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_ack_i,
  input  logic          dbus_err_i,
  input  logic [DW-1:0] dbus_rdata_i,
  output logic [DW-1:0] load_data_o,
  output logic          done_o,
  output logic          fault_o,
  output logic [1:0]    fault_cause_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [2:0]    f3;
    logic [1:0]    off;
  } acc_t;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_MIS  = 2'd1;
  localparam logic [1:0] C_BUS  = 2'd2;
  localparam logic [1:0] C_TMO  = 2'd3;

  state_t        state_q, state_d;
  acc_t          acc_q, acc_d;
  logic          req_q, req_d;
  logic [1:0]    cause_q, cause_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ld_q, ld_d;
  logic          latch;

  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          bad_f3;
  logic          misal;
  logic [3:0]    be_m;
  logic [DW-1:0] wd_m;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [DW-1:0] ext;
  logic          tmo_hit;

  always_comb begin
    is_byte = (func3_m[1:0] == 2'b00);
    is_half = (func3_m[1:0] == 2'b01);
    is_word = (func3_m[1:0] == 2'b10);
    bad_f3  = (func3_m == 3'b011) ||
              (func3_m[2:1] == 2'b11);
    misal   = bad_f3 ||
              (is_half && addr_m[0]) ||
              (is_word && (addr_m[1:0] != 2'b00));
  end

  always_comb begin
    be_m = 4'hf;
    wd_m = '0;
    if (mem_write_m) begin
      unique case (1'b1)
        is_byte: begin
          be_m = 4'b0001 << addr_m[1:0];
          wd_m = {4{wdata_m[7:0]}};
        end
        is_half: begin
          be_m = addr_m[1] ? 4'b1100 : 4'b0011;
          wd_m = {2{wdata_m[15:0]}};
        end
        default: begin
          be_m = 4'hf;
          wd_m = wdata_m;
        end
      endcase
    end
  end

  // Load lane select uses the offset captured when the access started.
  always_comb begin
    lb = dbus_rdata_i[7:0];
    unique case (acc_q.off)
      2'd0: lb = dbus_rdata_i[7:0];
      2'd1: lb = dbus_rdata_i[15:8];
      2'd2: lb = dbus_rdata_i[23:16];
      2'd3: lb = dbus_rdata_i[31:24];
    endcase
    lh = acc_q.off[1] ? dbus_rdata_i[31:16]
                      : dbus_rdata_i[15:0];
    case (acc_q.f3)
      3'b000:  ext = {{(DW-8){lb[7]}}, lb};
      3'b001:  ext = {{(DW-16){lh[15]}}, lh};
      3'b100:  ext = {{(DW-8){1'b0}}, lb};
      3'b101:  ext = {{(DW-16){1'b0}}, lh};
      default: ext = dbus_rdata_i;
    endcase
  end

  assign tmo_hit = (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_m) begin
          if (misal) begin
            state_d = DONE;
            cause_d = C_MIS;
            if (!mem_write_m) ld_d = '0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            cnt_d   = '0;
            latch   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dbus_err_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          cause_d = C_BUS;
          if (!acc_q.we) ld_d = '0;
        end else if (dbus_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          cause_d = C_NONE;
          if (!acc_q.we) ld_d = ext;
        end else if (tmo_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          cause_d = C_TMO;
          if (!acc_q.we) ld_d = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (latch) begin
      acc_d.we    = mem_write_m;
      acc_d.addr  = {addr_m[DW-1:2], 2'b00};
      acc_d.be    = be_m;
      acc_d.wdata = wd_m;
      acc_d.f3    = func3_m;
      acc_d.off   = addr_m[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      req_q   <= 1'b0;
      cause_q <= C_NONE;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end

  assign stall_o       = mem_req_m && (state_q != DONE);
  assign dbus_req_o    = req_q;
  assign dbus_we_o     = acc_q.we;
  assign dbus_addr_o   = acc_q.addr;
  assign dbus_be_o     = acc_q.be;
  assign dbus_wdata_o  = acc_q.wdata;
  assign load_data_o   = ld_q;
  assign done_o        = (state_q == DONE);
  assign fault_o       = done_o && (cause_q != C_NONE);
  assign fault_cause_o = cause_q;

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Memory-stage load/store sequencer for the 3-stage RISC-V core.
- Sits between the memory-stage outputs of the execute/memory pipeline register and a data bus with a req/ack handshake.
- Raises stall to hold that pipeline register while a multi-cycle access is outstanding.
- Builds byte enables and aligns write data; extracts and sign-extends load data; reports alignment, bus-error and timeout faults.

Parameters:
- DW, 32, data/address width (only 32 supported).
- TIMEOUT, 255, maximum BUSY cycles waiting for ack before a timeout fault; must be >= 1.
- TW, $clog2(TIMEOUT+1), timeout counter width (derived, do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- mem_req_m  in  1  memory-stage instruction is a load or store.
- mem_write_m  in  1  1 = store, 0 = load; valid with mem_req_m.
- func3_m  in  3  RISC-V funct3 of the memory-stage instruction.
- addr_m  in  DW  effective address (alu_out_m).
- wdata_m  in  DW  store data (write_data_m).
- stall_o  out  1  hold pipeline registers (combinational).
- dbus_req_o  out  1  bus request (registered).
- dbus_we_o  out  1  bus write enable.
- dbus_addr_o  out  DW  word-aligned address (addr_m with [1:0] = 0).
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  DW  lane-aligned write data.
- dbus_ack_i  in  1  transfer complete.
- dbus_err_i  in  1  transfer error; valid with ack or alone.
- dbus_rdata_i  in  DW  read data, valid when dbus_ack_i is high.
- load_data_o  out  DW  extracted and extended load result.
- done_o  out  1  one-cycle pulse: access finished (success or fault).
- fault_o  out  1  one-cycle pulse with done_o when the access faulted.
- fault_cause_o  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout; held until the next done_o.

Behaviour:
- Reset values: state IDLE; dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o, load_data_o, done_o, fault_o, fault_cause_o and the counter all 0.
- Reset is asynchronous. Reset mid-BUSY drops dbus_req_o immediately and any late ack is ignored.
- stall_o = mem_req_m && (state != DONE).
- Byte lanes:
  - SB: be = 1 << addr[1:0]; byte replicated on all four lanes.
  - SH: be = 0011 or 1100 by addr[1]; half replicated on both halves.
  - SW: be = 1111.
  - Loads drive be = 1111, we = 0, wdata = 0.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Unsupported func3 (011, 110, 111) is treated as misaligned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_req_m aligned -> BUSY. Register req=1 and the we/addr/be/wdata values; clear the counter.
  - mem_req_m misaligned -> DONE with cause 1. No bus request is issued.
  - No request -> stay in IDLE.
- BUSY (req held high, all bus outputs stable):
  - dbus_err_i -> DONE, cause 2. Error wins over ack in the same cycle.
  - dbus_ack_i -> DONE, cause 0. Capture extracted rdata into load_data_o on loads.
  - counter == TIMEOUT-1 with no ack/err -> DONE, cause 3.
  - Otherwise the counter increments.
  - dbus_req_o deasserts on the cycle after ack/err/timeout.
- DONE (exactly one cycle):
  - done_o=1; fault_o=1 when cause != 0; stall_o=0 so the pipeline advances.
  - Then -> IDLE unconditionally. A following memory instruction is detected in IDLE on the next cycle.
- Load extraction from the captured word, using the byte/half selected by the latched addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- load_data_o holds until the next successful load. On a faulted load it is 0.
- Latency: aligned access with ack in the first BUSY cycle takes 3 cycles from mem_req_m to pipeline advance (IDLE, BUSY, DONE). Each ack wait cycle adds 1.
- Misaligned access takes 2 cycles.
- Inputs (addr_m, wdata_m, func3_m) are held stable by the stall; the block latches them on IDLE->BUSY regardless.

Test Plan:
- Aligned word store: SW addr=0x100, wdata=0xDEADBEEF, ack 2 cycles after req.
  - req/we/be=1111 held for 3 BUSY cycles, stall high 4 cycles, then done_o pulse, fault_o=0.
- Byte load with sign extension: LB addr=0x203, rdata=0x80FF_1234.
  - load_data_o=0xFFFFFF80.
  - Same access with LBU gives 0x00000080.
  - LHU addr=0x202 gives 0x000080FF.
- Misaligned word access: LW addr=0x102.
  - No dbus_req_o ever asserted; done_o and fault_o pulse 1 cycle after request; cause=1; stall high exactly 1 cycle.
- Bus error: SH addr=0x4 (be=0011), err and ack together in the 1st BUSY cycle.
  - cause=2, fault_o=1, load_data_o unchanged.
- Timeout: TIMEOUT=4, never ack.
  - Exactly 4 BUSY cycles, then cause=3, req drops the next cycle, pipeline released.
- Reset and back-to-back:
  - Assert rst_i mid-BUSY: req drops asynchronously, all outputs 0; an ack after reset causes no done_o.
  - Two back-to-back SW with immediate acks: two done_o pulses 3 cycles apart.
